// File: rtl/data_bus_responder_pkg.sv
// rtl/data_bus_responder_pkg.sv - shared region constants, timer register map and timer FSM state type
package data_bus_responder_pkg;
    localparam logic [31:0] DM_BASE        = 32'h0000_0000;
    localparam int          TMR_REG_WORDS  = 3;
    localparam logic [1:0]  TMR_OFF_CTRL   = 2'd0;
    localparam logic [1:0]  TMR_OFF_PRESET = 2'd1;
    localparam logic [1:0]  TMR_OFF_COUNT  = 2'd2;
    localparam int          CTRL_EN_BIT    = 0;
    localparam int          CTRL_MODE_LSB  = 1;
    localparam int          CTRL_IM_BIT    = 3;
    localparam logic [1:0]  MODE_ONESHOT   = 2'd0;
    localparam logic [1:0]  MODE_RELOAD    = 2'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} tmr_state_e;
endpackage

// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - CPU M-stage data bus (address, lane-aligned write data, byte enables, read data)
interface data_bus_responder_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport master (output m_data_addr, m_data_wdata, m_data_byteen, input m_data_rdata);
    modport slave  (input m_data_addr, m_data_wdata, m_data_byteen, output m_data_rdata);
endinterface

// File: rtl/data_bus_responder_bus_timer.sv
// rtl/data_bus_responder_bus_timer.sv - bus_timer: CTRL/PRESET/COUNT registers, countdown FSM and irq
// Compiled only when BUS_TIMER_EN is defined.
`ifdef BUS_TIMER_EN
module bus_timer
    import data_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  off,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    tmr_state_e  state, state_n;
    logic        en, en_n, im, im_n, flag, flag_n;
    logic [1:0]  mode, mode_n;
    logic [31:0] preset, preset_n, count, count_n;
    logic        wr_ctrl, wr_preset;

    assign wr_ctrl   = sel && (byteen == 4'hF) && (off == TMR_OFF_CTRL);
    assign wr_preset = sel && (byteen == 4'hF) && (off == TMR_OFF_PRESET);

    always_comb begin
        state_n  = state;
        en_n     = en;
        mode_n   = mode;
        im_n     = im;
        flag_n   = flag;
        preset_n = preset;
        count_n  = count;
        case (state)
            ST_IDLE: if (en) state_n = ST_LOAD;
            ST_LOAD: begin
                count_n = preset;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (count == 32'd0) begin
                    state_n = ST_INT;
                    flag_n  = 1'b1;
                end else begin
                    count_n = count - 32'd1;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    state_n = ST_LOAD;
                    flag_n  = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // CPU writes are applied last so they override same-edge FSM updates
        if (wr_ctrl) begin
            en_n   = wdata[CTRL_EN_BIT];
            mode_n = wdata[CTRL_MODE_LSB +: 2];
            im_n   = wdata[CTRL_IM_BIT];
            flag_n = 1'b0;
        end
        if (wr_preset) begin
            preset_n = wdata;
            flag_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            en     <= 1'b0;
            mode   <= 2'd0;
            im     <= 1'b0;
            flag   <= 1'b0;
            preset <= 32'h0;
            count  <= 32'h0;
            irq    <= 1'b0;
        end else begin
            state  <= state_n;
            en     <= en_n;
            mode   <= mode_n;
            im     <= im_n;
            flag   <= flag_n;
            preset <= preset_n;
            count  <= count_n;
            irq    <= im_n & flag_n;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (off)
            TMR_OFF_CTRL:   rdata = {28'h0, im, mode, en};
            TMR_OFF_PRESET: rdata = preset;
            TMR_OFF_COUNT:  rdata = count;
            default:        rdata = 32'h0;
        endcase
    end
endmodule
`endif

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data RAM, address decode and read mux for the CPU data bus
// Optional timer block is included when BUS_TIMER_EN is defined; otherwise its region is unmapped.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DM_WORDS = 3072,
    parameter logic [31:0] TMR_BASE = 32'h0000_7F00
)(
    input  logic                 clk,
    input  logic                 reset,
    data_bus_responder_if.slave  bus,
    output logic                 irq
);
    localparam int DM_AW = $clog2(DM_WORDS);

    logic [31:0]      dm [DM_WORDS];
    logic [29:0]      word_addr, dm_off, tmr_off;
    logic             dm_sel, tmr_sel;
    logic [DM_AW-1:0] dm_idx;
    logic [31:0]      dm_rdata, tmr_rdata;
    logic             unused_lsbs;

    assign unused_lsbs = ^bus.m_data_addr[1:0];
    assign word_addr   = bus.m_data_addr[31:2];
    assign dm_off      = word_addr - DM_BASE[31:2];
    assign tmr_off     = word_addr - TMR_BASE[31:2];
    assign dm_sel      = {2'b00, dm_off} < 32'(DM_WORDS);
    assign tmr_sel     = tmr_off < 30'(TMR_REG_WORDS);
    assign dm_idx      = dm_off[DM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm[i] <= 32'h0;
        end else if (dm_sel) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_data_byteen[b]) dm[dm_idx][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
        end
    end

    assign dm_rdata = dm[dm_idx];

`ifdef BUS_TIMER_EN
    bus_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .sel    (tmr_sel),
        .off    (tmr_off[1:0]),
        .byteen (bus.m_data_byteen),
        .wdata  (bus.m_data_wdata),
        .rdata  (tmr_rdata),
        .irq    (irq)
    );
`else
    assign tmr_rdata = 32'h0;
    assign irq       = 1'b0;
`endif

    assign bus.m_data_rdata = dm_sel  ? dm_rdata  :
                              tmr_sel ? tmr_rdata : 32'h0;
endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder; timer checks run when BUS_TIMER_EN is defined
`timescale 1ns/1ps
module tb_data_bus_responder;
    localparam logic [31:0] TB_TMR   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = TB_TMR;
    localparam logic [31:0] A_PRESET = TB_TMR + 32'h4;
    localparam logic [31:0] A_COUNT  = TB_TMR + 32'h8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    logic stb = 1'b0;
    logic kick = 1'b0;

    data_bus_responder_if bus();

    data_bus_responder #(.DM_WORDS(3072), .TMR_BASE(TB_TMR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_irq;
        logic        exp_irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor: samples on the falling edge, or on kick for off-edge reset checks
    always @(negedge clk or posedge kick) begin
        if (stb) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: strobe with no expected entry");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk_rd) begin
                    n_checks++;
                    if (bus.m_data_rdata === mon_e.exp_rd) n_pass++;
                    else $display("FAIL %s: rdata=%h expected=%h @%0t", mon_e.name, bus.m_data_rdata, mon_e.exp_rd, $time);
                end
                if (mon_e.chk_irq) begin
                    n_checks++;
                    if (irq === mon_e.exp_irq) n_pass++;
                    else $display("FAIL %s: irq=%b expected=%b @%0t", mon_e.name, irq, mon_e.exp_irq, $time);
                end
            end
        end
    end

    task automatic push(input string nm, input bit crd, input logic [31:0] erd, input bit cirq, input logic eirq);
        exp_t te;
        te.name = nm; te.chk_rd = crd; te.exp_rd = erd; te.chk_irq = cirq; te.exp_irq = eirq;
        sb.push_back(te);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.m_data_addr = a; bus.m_data_wdata = d; bus.m_data_byteen = be;
        @(posedge clk); #1;
        bus.m_data_byteen = 4'h0;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input bit crd, input logic [31:0] erd,
                       input bit cirq, input logic eirq);
        bus.m_data_addr = a; bus.m_data_byteen = 4'h0;
        push(nm, crd, erd, cirq, eirq);
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] erd);
        chk(nm, a, 1'b1, erd, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] cnt_tab [13];
        cnt_tab = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
        bus.m_data_addr = 32'h0; bus.m_data_wdata = 32'h0; bus.m_data_byteen = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", A_CTRL, 1'b1, 32'h0, 1'b1, 1'b0);
        rd("reset_dm", 32'h10, 32'h0);
        reset = 1'b0;

        // data RAM
        wr(32'h10, 32'h1122_3344, 4'b1111);
        wr(32'h10, 32'h00AA_0000, 4'b0100);
        rd("dm_byte_lane2", 32'h10, 32'h11AA_3344);
        rd("dm_addr_lsbs_ignored", 32'h13, 32'h11AA_3344);
        wr(32'h14, 32'hCAFE_F00D, 4'b0011);
        rd("dm_halfword", 32'h14, 32'h0000_F00D);
        wr(32'h2FFC, 32'hA5A5_5A5A, 4'b1111);
        rd("dm_last_word", 32'h2FFC, 32'hA5A5_5A5A);
        wr(32'h3000, 32'h1234_5678, 4'b1111);
        rd("unmapped_3000", 32'h3000, 32'h0);
        rd("no_alias_0000", 32'h0000, 32'h0);
        wr(32'h5000, 32'hDEAD_BEEF, 4'b1111);
        rd("unmapped_5000", 32'h5000, 32'h0);
        rd("no_alias_1000", 32'h1000, 32'h0);
        rd("unmapped_past_timer", TB_TMR + 32'hC, 32'h0);

`ifdef BUS_TIMER_EN
        // one-shot: PRESET=5, irq 8 edges after CTRL write
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int i = 0; i <= 8; i++)
            chk("oneshot_seq", A_COUNT, 1'b1, (i >= 2 && i <= 7) ? 32'(7 - i) : 32'h0, 1'b1, (i == 8));
        chk("oneshot_count0", A_COUNT, 1'b1, 32'h0, 1'b1, 1'b1);
        chk("oneshot_ctrl_en_clr", A_CTRL, 1'b1, 32'h8, 1'b1, 1'b1);
        rd("preset_readback", A_PRESET, 32'd5);
        wr(A_CTRL, 32'h8, 4'hF);
        chk("oneshot_ack", A_CTRL, 1'b1, 32'h8, 1'b1, 1'b0);

        // auto-reload: PRESET=2, pulses every 5 edges
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int i = 0; i <= 12; i++)
            chk("reload_seq", A_COUNT, 1'b1, cnt_tab[i], 1'b1, (i == 5 || i == 10));
        wr(A_CTRL, 32'h0, 4'hF);
        chk("reload_stop", A_CTRL, 1'b1, 32'h0, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // disable mid-count freezes COUNT and returns to IDLE
        wr(A_PRESET, 32'd10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i <= 5; i++)
            chk("mask_count", A_COUNT, 1'b1, (i < 2) ? 32'h0 : 32'(12 - i), 1'b1, 1'b0);
        wr(A_CTRL, 32'h0, 4'hF);
        for (int i = 0; i <= 2; i++) rd("disable_freeze", A_COUNT, 32'd5);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i <= 2; i++) rd("reenable_reload", A_COUNT, (i == 2) ? 32'd10 : 32'd5);
        wr(A_CTRL, 32'h0, 4'hF);
        repeat (2) begin @(posedge clk); #1; end

        // IM=0 with PRESET=0: interrupt fires internally but irq stays low
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i <= 5; i++)
            chk("masked_irq", A_CTRL, 1'b1, (i < 4) ? 32'h1 : 32'h0, 1'b1, 1'b0);
        wr(A_CTRL, 32'h8, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int i = 0; i <= 4; i++)
            chk("preset0_latency", A_COUNT, 1'b1, 32'h0, 1'b1, (i >= 3));
        wr(A_CTRL, 32'h0, 4'hF);
        chk("preset0_ack", A_CTRL, 1'b1, 32'h0, 1'b1, 1'b0);

        // partial writes and COUNT writes are ignored
        wr(A_CTRL, 32'h9, 4'b0011);
        rd("partial_ctrl", A_CTRL, 32'h0);
        wr(A_PRESET, 32'h77, 4'b1110);
        rd("partial_preset", A_PRESET, 32'h0);
        wr(A_COUNT, 32'h55, 4'hF);
        rd("count_readonly", A_COUNT, 32'h0);

        // asynchronous reset while COUNT=3
        wr(A_PRESET, 32'd6, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int i = 0; i <= 4; i++)
            chk("prereset_count", A_COUNT, 1'b1, (i < 2) ? 32'h0 : 32'(8 - i), 1'b1, 1'b0);
        bus.m_data_addr = A_COUNT;
        push("prereset_count3", 1'b1, 32'd3, 1'b1, 1'b0);
        stb = 1'b1;
        @(negedge clk); #1;
        reset = 1'b1;
        push("async_reset_count", 1'b1, 32'h0, 1'b1, 1'b0);
        #1 kick = 1'b1;
        #1 kick = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        rd("async_reset_ctrl", A_CTRL, 32'h0);
        rd("async_reset_preset", A_PRESET, 32'h0);
        rd("async_reset_dm", 32'h10, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) chk("no_pending_irq", A_COUNT, 1'b1, 32'h0, 1'b1, 1'b0);
`else
        // timer absent: region unmapped, irq tied low
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int i = 0; i < 10; i++) chk("no_timer_ctrl", A_CTRL, 1'b1, 32'h0, 1'b1, 1'b0);
        rd("no_timer_preset", A_PRESET, 32'h0);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        rd("reset_clears_dm", 32'h10, 32'h0);
        reset = 1'b0;
`endif

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: %0d entries expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter DM_WORDS, default 3072, data RAM depth in 32-bit words (byte range 0x0000..0x2FFF).
REQ-002 SHALL have parameter TMR_BASE, default 32'h0000_7F00, timer register block base address.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port m_data_addr, input, 32, CPU data byte address (M stage).
REQ-006 SHALL have port m_data_wdata, input, 32, write data, already lane-aligned by the CPU.
REQ-007 SHALL have port m_data_byteen, input, 4, byte-lane write enables; 4'b0000 means read or no access.
REQ-008 SHALL have port m_data_rdata, output, 32, read data for the word at m_data_addr.
REQ-009 SHALL have port irq, output, 1, timer interrupt, wired to CPU itr[2].

Function
REQ-010 Decode SHALL use word address m_data_addr[31:2]; m_data_addr[1:0] is ignored.
REQ-011 Region map: DM for addr < DM_WORDS*4; timer for TMR_BASE..TMR_BASE+0xB; anything else unmapped.
REQ-012 m_data_rdata SHALL be combinational from the current address (zero-latency read); unmapped reads SHALL return 0.
REQ-013 DM write: on the clock edge, each lane i with m_data_byteen[i]=1 SHALL update byte i; other lanes SHALL be preserved.
REQ-014 Writes to unmapped addresses SHALL be ignored with no side effect.
REQ-015 Timer registers: +0x0 CTRL (bit0 EN, bits2:1 MODE, bit3 IM, other bits read 0); +0x4 PRESET (read/write); +0x8 COUNT (read-only).
REQ-016 Timer writes SHALL take effect only when byteen=4'b1111; partial writes and writes to COUNT SHALL be ignored.
REQ-017 Timer FSM states: IDLE, LOAD, CNT, INT.
REQ-018 IDLE->LOAD on the first edge at which EN=1.
REQ-019 LOAD->CNT with COUNT<=PRESET.
REQ-020 In CNT, COUNT SHALL decrement by 1 per edge while COUNT!=0; at COUNT==0 the FSM SHALL go to INT; if EN=0 it SHALL go to IDLE instead and COUNT SHALL hold.
REQ-021 Entering INT SHALL set irq_flag.
REQ-022 INT in MODE=0 (one-shot) SHALL go to IDLE, clear EN, and keep irq_flag until any timer CTRL or PRESET write.
REQ-023 INT in MODE=1 (auto-reload) SHALL go to LOAD and clear irq_flag on the next edge, giving a one-cycle pulse.
REQ-024 MODE values 2 and 3 SHALL behave as MODE=0.
REQ-025 irq SHALL equal IM AND irq_flag, registered-state driven and glitch-free.
REQ-026 PRESET=0: LOAD->CNT->INT with no decrement.
REQ-027 A PRESET write during CNT SHALL affect only the next LOAD.
REQ-028 Same-edge CPU CTRL write and FSM EN-clear: the CPU write SHALL win.
REQ-029 Same-edge flag-clearing write and INT entry: the clear SHALL win.
REQ-030 Latency from the CTRL write edge (EN=1, PRESET=N) to irq high SHALL be N+3 edges.

Reset
REQ-031 Reset SHALL be asynchronous: FSM=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0, irq=0.
REQ-032 Reset mid-count SHALL abort immediately with no pending interrupt.
REQ-033 DM contents SHALL be cleared to 0 on reset (simulation model).

Configuration
REQ-034 Macro BUS_TIMER_EN defined: the timer is present as specified.
REQ-035 Macro BUS_TIMER_EN undefined: no timer logic; the timer region SHALL be unmapped (reads 0, writes ignored) and irq SHALL be tied to 0.

Structure
REQ-036 A shared package SHALL hold: region base/limit constants, timer register offsets, CTRL bit positions, MODE encodings, and the FSM state enum.
REQ-037 The timer SHALL be a single sub-module, bus_timer, holding registers, FSM and irq.
REQ-038 The top level SHALL contain the DM array, address decode and read mux only.

Verification
REQ-039 DM byte write: sw 0x11223344 @0x10, then byteen=0100 wdata=0x00AA0000 @0x10 -> read 0x11AA3344.
REQ-040 One-shot: PRESET=5, CTRL=0x9 -> irq rises exactly 8 edges after the CTRL write and stays high, COUNT=0, CTRL read=0x8; a subsequent CTRL write drops irq.
REQ-041 Auto-reload: PRESET=2, CTRL=0xB -> irq one-cycle pulses repeating every 5 edges, with COUNT cycling 2,1,0.
REQ-042 Masking and disable: CTRL=0x1 (IM=0) -> irq stays 0; CTRL=0x0 written mid-count -> COUNT freezes and the FSM returns to IDLE.
REQ-043 Unmapped and partial: write 0xDEADBEEF @0x5000 -> read 0; sh to CTRL -> CTRL unchanged.
REQ-044 Reset asserted while COUNT=3 in CNT -> all registers 0 and irq=0 immediately, without waiting for a clock edge.
